// File: rtl/ahblite_spi_master.sv
// AHB-Lite slave with a mode-3 SPI shift engine (SCLK idles high, MOSI driven
// on the falling edge, MISO sampled on the rising edge, MSB first).
// Software writes DATA to start a transfer, then polls STATUS or waits for
// spi_done_irq. Chip select is a plain register bit and is never toggled here.
module ahblite_spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        SPI_CS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  input  logic        SPI_IRQ,
  output logic        spi_done_irq
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t              state, state_n;
  logic                sel_q, wr_q;
  logic [1:0]          addr_q;
  logic [DIV_W-1:0]    div, hcnt;
  logic [BW-1:0]       bcnt;
  logic [DATA_W-1:0]   tx, rx;
  logic                sclk, cs, ie, done, ovr, irq_q;
  logic [1:0]          irq_sync;
  logic                busy, tick, start, rise, fall, fin;
  logic                wr_en, wr_ctrl, wr_div, wr_data, wr_stat;
  logic                unused;

  assign HREADYOUT    = 1'b1;
  assign HRESP        = 1'b0;
  assign SPI_CS       = cs;
  assign SPI_CLK      = sclk;
  assign SPI_MOSI     = tx[DATA_W-1];
  assign spi_done_irq = irq_q;
  assign busy         = (state != IDLE);
  assign unused       = ^{HADDR[31:4], HADDR[1:0], HSIZE, HPROT, HWDATA};

  // Register the address phase; decode writes in the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
    end else if (HREADY) begin
      sel_q  <= HSEL & HTRANS[1];
      wr_q   <= HWRITE;
      addr_q <= HADDR[3:2];
    end
  end

  assign wr_en   = sel_q & wr_q & HREADY;
  assign wr_ctrl = wr_en & (addr_q == 2'd0);
  assign wr_div  = wr_en & (addr_q == 2'd1);
  assign wr_data = wr_en & (addr_q == 2'd2);
  assign wr_stat = wr_en & (addr_q == 2'd3);

  // Engine state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_n;
  end

  // Next state plus one-cycle event strobes for the datapath.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    fin     = 1'b0;
    tick    = (hcnt == div);
    case (state)
      IDLE: if (wr_data) begin state_n = LOW; start = 1'b1; end
      LOW:  if (tick) begin state_n = HIGH; rise = 1'b1; end
      HIGH: if (tick) begin
              if (bcnt == LAST_BIT) begin state_n = IDLE; fin  = 1'b1; end
              else                  begin state_n = LOW;  fall = 1'b1; end
            end
      default: state_n = IDLE;
    endcase
  end

  // Shift datapath: half-period counter, bit counter, SCLK, TX/RX shifters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hcnt <= '0;
      bcnt <= '0;
      tx   <= '0;
      rx   <= '0;
      sclk <= 1'b1;
    end else begin
      if (state_n != state || state == IDLE) hcnt <= '0;
      else                                   hcnt <= hcnt + 1'b1;
      if (start) begin
        tx   <= HWDATA[DATA_W-1:0];
        bcnt <= '0;
        sclk <= 1'b0;
      end
      if (rise) begin
        sclk <= 1'b1;
        rx   <= {rx[DATA_W-2:0], SPI_MISO};
      end
      if (fall) begin
        sclk <= 1'b0;
        tx   <= {tx[DATA_W-2:0], 1'b0};
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Control/status registers; completion set beats a same-cycle W1C.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cs       <= 1'b1;
      ie       <= 1'b0;
      div      <= '0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      irq_q    <= 1'b0;
      irq_sync <= 2'b00;
    end else begin
      if (wr_ctrl) {ie, cs} <= HWDATA[1:0];
      if (wr_div && !busy) div <= HWDATA[DIV_W-1:0];
      if (fin)                        done <= 1'b1;
      else if (start)                 done <= 1'b0;
      else if (wr_stat && HWDATA[1])  done <= 1'b0;
      if (wr_data && busy)            ovr <= 1'b1;
      else if (wr_stat && HWDATA[2])  ovr <= 1'b0;
      irq_q    <= done & ie;
      irq_sync <= {irq_sync[0], SPI_IRQ};
    end
  end

  // Read mux driven by the registered address.
  always_comb begin
    HRDATA = '0;
    case (addr_q)
      2'd0: HRDATA[1:0]        = {ie, cs};
      2'd1: HRDATA[DIV_W-1:0]  = div;
      2'd2: HRDATA[DATA_W-1:0] = rx;
      2'd3: HRDATA[3:0]        = {irq_sync[1], ovr, done, busy};
      default: HRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_ahblite_spi_master.sv
// Directed + randomized bench for ahblite_spi_master with a transfer-level
// reference: expected RX is the MISO pattern (or the TX word in loopback),
// MOSI must replay the TX word MSB first, every SCLK half lasts DIV+1 cycles
// and BUSY lasts 2*DATA_W*(DIV+1) cycles.
module tb_ahblite_spi_master;

  localparam int W = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [3:0]  HPROT = 4'b0011;
  logic        HREADYOUT, HRESP, SPI_CS, SPI_CLK, SPI_MOSI, SPI_MISO, spi_done_irq;
  logic [31:0] HRDATA;
  logic        SPI_IRQ = 1'b0;

  int checks = 0, errors = 0;

  logic        loop_en = 1'b0, miso_r = 1'b0;
  logic [31:0] miso_pat = '0, mosi_cap = '0;
  int          falls = 0, fall_base = 0, rises = 0, rise_base = 0, ebase = 0;
  time         edge_t[$];
  logic [31:0] cur_data, exp_rx;
  int          cur_div;
  time         t0;
  logic        irq_at_done, irq_next;

  ahblite_spi_master #(.DATA_W(W), .DIV_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .SPI_CS(SPI_CS),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_IRQ(SPI_IRQ),
    .spi_done_irq(spi_done_irq)
  );

  always #5 HCLK = ~HCLK;

  assign SPI_MISO = loop_en ? SPI_MOSI : miso_r;

  // Device model: present the next pattern bit after each SCLK falling edge.
  always @(negedge SPI_CLK) begin : miso_drv
    int k;
    k = falls - fall_base;
    miso_r = (k >= 0 && k < W) ? miso_pat[W-1-k] : 1'b0;
    falls++;
  end

  // Device model: capture MOSI on each SCLK rising edge.
  always @(posedge SPI_CLK) begin
    rises++;
    mosi_cap = {mosi_cap[30:0], SPI_MOSI};
  end

  // Log every SCLK edge time for half-period checking.
  always @(SPI_CLK) edge_t.push_back($time);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic xfer_start(input logic [31:0] data, input logic [31:0] pat,
                            input logic lp, input int div);
    cur_data  = data & MASK;
    exp_rx    = lp ? (data & MASK) : (pat & MASK);
    cur_div   = div;
    loop_en   = lp;
    miso_pat  = pat;
    fall_base = falls;
    rise_base = rises;
    ebase     = edge_t.size();
    ahb_write(32'h8, data);
    t0 = $time;
  endtask

  task automatic xfer_finish(input string tag);
    logic [31:0] st, rd;
    int n, bad, len;
    n = 0; bad = 0;
    do begin
      ahb_read(32'hC, st);
      n++;
    end while (st[0] && n < 5000);
    irq_at_done = spi_done_irq;
    chk({tag, " busy_clear"}, {31'd0, st[0]}, 32'd0);
    len = int'(($time - t0) / 10);
    chk({tag, " busy_len"}, len, 2 * W * (cur_div + 1));
    chk({tag, " sclk_pulses"}, rises - rise_base, W);
    chk({tag, " mosi_bits"}, mosi_cap & MASK, cur_data);
    chk({tag, " sclk_edges"}, edge_t.size() - ebase, 2 * W);
    for (int i = ebase + 1; i < ebase + 2 * W && i < edge_t.size(); i++)
      if (edge_t[i] - edge_t[i-1] != time'((cur_div + 1) * 10)) bad++;
    chk({tag, " half_period"}, bad, 0);
    chk({tag, " done"}, {31'd0, st[1]}, 32'd1);
    ahb_read(32'h8, rd);
    irq_next = spi_done_irq;
    chk({tag, " rx"}, rd, exp_rx);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] d, p;
    logic lp;
    int dv, n, hi, rb;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst cs", {31'd0, SPI_CS}, 32'd1);
    chk("rst sclk", {31'd0, SPI_CLK}, 32'd1);
    chk("rst mosi", {31'd0, SPI_MOSI}, 32'd0);
    chk("rst irq", {31'd0, spi_done_irq}, 32'd0);
    HRESETn = 1'b1;
    ahb_read(32'hC, rd); chk("rst status", rd, 32'h0);
    ahb_read(32'h8, rd); chk("rst rx", rd, 32'h0);
    ahb_read(32'h0, rd); chk("rst ctrl", rd, 32'h1);
    ahb_read(32'h4, rd); chk("rst div", rd, 32'h0);

    // SPI_IRQ reaches STATUS[3] through the synchroniser
    SPI_IRQ = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    ahb_read(32'hC, rd); chk("irq_sync", rd, 32'h8);

    // Loopback, DIV=0
    ahb_write(32'h0, 32'h0);
    chk("cs low", {31'd0, SPI_CS}, 32'd0);
    xfer_start(32'hA5, 32'h0, 1'b1, 0);
    xfer_finish("t2");
    chk("t2 no_irq", {31'd0, irq_next}, 32'd0);

    // DIV=3, MISO tied high
    ahb_write(32'h4, 32'h3);
    xfer_start(32'h3C, 32'hFF, 1'b0, 3);
    xfer_finish("t3");

    // Overrun: DATA and DIV writes mid-transfer are dropped
    xfer_start(32'h96, 32'h6B, 1'b0, 3);
    repeat (2) @(posedge HCLK);
    #1;
    ahb_write(32'h8, 32'h5A);
    ahb_write(32'h4, 32'h9);
    xfer_finish("t4");
    ahb_read(32'hC, rd); chk("t4 ovr", rd & 32'h7, 32'h6);
    ahb_read(32'h4, rd); chk("t4 div_kept", rd, 32'h3);
    ahb_write(32'hC, 32'h4);
    ahb_read(32'hC, rd); chk("t4 ovr_w1c", rd & 32'h7, 32'h2);

    // Randomized transfers
    for (int it = 0; it < 6; it++) begin
      d  = $urandom & MASK;
      p  = $urandom & MASK;
      lp = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 4);
      ahb_write(32'h4, dv);
      xfer_start(d, p, lp, dv);
      xfer_finish("rand");
    end

    // Completion interrupt and its W1C
    ahb_write(32'hC, 32'h6);
    ahb_write(32'h0, 32'h2);
    chk("t5 irq_idle", {31'd0, spi_done_irq}, 32'd0);
    ahb_write(32'h4, 32'h1);
    xfer_start(32'hC7, 32'h3A, 1'b0, 1);
    xfer_finish("t5");
    chk("t5 irq_lag", {31'd0, irq_at_done}, 32'd0);
    chk("t5 irq_set", {31'd0, irq_next}, 32'd1);
    ahb_write(32'hC, 32'h2);
    chk("t5 irq_hold", {31'd0, spi_done_irq}, 32'd1);
    @(posedge HCLK); #1;
    chk("t5 irq_clr", {31'd0, spi_done_irq}, 32'd0);

    // Reset in the middle of bit 3
    ahb_write(32'h4, 32'h3);
    xfer_start(32'hF0, 32'h0, 1'b0, 3);
    n = 0;
    while (rises - rise_base < 3 && n < 500) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk("t6 reach_bit3", rises - rise_base, 3);
    repeat (5) @(posedge HCLK);
    #1;
    chk("t6 pre_sclk", {31'd0, SPI_CLK}, 32'd0);
    chk("t6 pre_mosi", {31'd0, SPI_MOSI}, 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("t6 sclk", {31'd0, SPI_CLK}, 32'd1);
    chk("t6 cs", {31'd0, SPI_CS}, 32'd1);
    chk("t6 mosi", {31'd0, SPI_MOSI}, 32'd0);
    chk("t6 irq", {31'd0, spi_done_irq}, 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    rb = rises;
    ahb_read(32'hC, rd); chk("t6 status", rd & 32'h7, 32'h0);
    hi = 0;
    repeat (40) begin
      @(posedge HCLK); #1;
      if (spi_done_irq) hi++;
    end
    chk("t6 no_irq", hi, 0);
    chk("t6 sclk_quiet", rises - rb, 0);
    ahb_read(32'h0, rd); chk("t6 ctrl", rd, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
